// File: rtl/uart_order_parser.sv
// uart_order_parser
//   Consumes bytes from the UART receiver through the rx_ready/rx_clear pop
//   handshake. It assembles fixed-format order frames:
//     SOF, TYPE, SYM, PRICE[PRICE_BYTES] (MSB first), QTY[2] (MSB first), CKSUM
//   Each frame is validated for type, XOR checksum and inter-byte timeout.
//   A good frame is presented as one order on a valid/ready output.
//
// Ports
//   clk, rst                     system clock, synchronous active-high reset
//   rx_ready, rx_data            byte offered by the receiver
//   rx_clear                     one-cycle pop strobe back to the receiver
//   ord_valid, ord_ready         order handshake toward the matching engine
//   ord_side/sym/price/qty       parsed order fields, stable while ord_valid
//   err_cksum/type/timeout/overrun  one-cycle error pulses
//
// state   | meaning
// --------+-------------------------------------------------------------
// HUNT    | discard bytes until SOF_BYTE
// TYPE    | expect type byte (01 buy, 02 sell)
// SYM     | expect symbol id
// PRICE   | collect PRICE_BYTES price bytes, MSB first
// QTY     | collect 2 quantity bytes, MSB first
// CKSUM   | expect checksum byte, then validate and publish
module uart_order_parser #(
  parameter int          PRICE_BYTES    = 4,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_ready,
  input  logic [7:0]               rx_data,
  output logic                     rx_clear,
  output logic                     ord_valid,
  input  logic                     ord_ready,
  output logic                     ord_side,
  output logic [7:0]               ord_sym,
  output logic [8*PRICE_BYTES-1:0] ord_price,
  output logic [15:0]              ord_qty,
  output logic                     err_cksum,
  output logic                     err_type,
  output logic                     err_timeout,
  output logic                     err_overrun
);

  localparam int PW = 8 * PRICE_BYTES;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(PRICE_BYTES + 1);

  typedef enum logic [2:0] {
    S_HUNT, S_TYPE, S_SYM, S_PRICE, S_QTY, S_CKSUM
  } state_t;

  state_t          state_q, state_d;
  logic            rx_clear_q, rx_clear_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      xor_q, xor_d;
  logic [7:0]      type_q, type_d;
  logic [7:0]      sym_q, sym_d;
  logic [PW-1:0]   price_q, price_d;
  logic [15:0]     qty_q, qty_d;
  logic            ord_valid_q, ord_valid_d;
  logic            ord_side_q, ord_side_d;
  logic [7:0]      ord_sym_q, ord_sym_d;
  logic [PW-1:0]   ord_price_q, ord_price_d;
  logic [15:0]     ord_qty_q, ord_qty_d;
  logic            err_cksum_q, err_cksum_d;
  logic            err_type_q, err_type_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_overrun_q, err_overrun_d;

  logic            accept;
  logic            timeout;
  logic            load;

  always_comb begin
    state_d       = state_q;
    idle_d        = idle_q;
    cnt_d         = cnt_q;
    xor_d         = xor_q;
    type_d        = type_q;
    sym_d         = sym_q;
    price_d       = price_q;
    qty_d         = qty_q;
    ord_side_d    = ord_side_q;
    ord_sym_d     = ord_sym_q;
    ord_price_d   = ord_price_q;
    ord_qty_d     = ord_qty_q;
    ord_valid_d   = ord_valid_q & ~ord_ready;
    err_cksum_d   = 1'b0;
    err_type_d    = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    timeout       = 1'b0;
    load          = 1'b0;

    // A pop strobe blocks acceptance for one cycle so the receiver can drop rx_ready.
    accept     = rx_ready & ~rx_clear_q;
    rx_clear_d = accept;

    // An accepted byte in the limit cycle takes priority over the timeout.
    if (state_q == S_HUNT || accept) begin
      idle_d = '0;
    end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
      idle_d  = '0;
      timeout = 1'b1;
    end else begin
      idle_d = idle_q + IW'(1);
    end

    if (accept) begin
      case (state_q)
        S_HUNT: begin
          if (rx_data == SOF_BYTE) begin
            state_d = S_TYPE;
            xor_d   = 8'h00;
          end
        end
        S_TYPE: begin
          type_d  = rx_data;
          xor_d   = xor_q ^ rx_data;
          state_d = S_SYM;
        end
        S_SYM: begin
          sym_d   = rx_data;
          xor_d   = xor_q ^ rx_data;
          cnt_d   = '0;
          state_d = S_PRICE;
        end
        S_PRICE: begin
          price_d = PW'({price_q, rx_data});
          xor_d   = xor_q ^ rx_data;
          if (cnt_q == CW'(PRICE_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = S_QTY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_QTY: begin
          qty_d = 16'({qty_q, rx_data});
          xor_d = xor_q ^ rx_data;
          if (cnt_q == CW'(1)) begin
            cnt_d   = '0;
            state_d = S_CKSUM;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_CKSUM: begin
          state_d = S_HUNT;
          if (rx_data != xor_q) begin
            err_cksum_d = 1'b1;
          end else if (type_q != 8'h01 && type_q != 8'h02) begin
            err_type_d = 1'b1;
          end else if (ord_valid_q && !ord_ready) begin
            err_overrun_d = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
        default: state_d = S_HUNT;
      endcase
    end

    if (timeout) begin
      state_d       = S_HUNT;
      err_timeout_d = 1'b1;
    end

    if (load) begin
      ord_valid_d = 1'b1;
      ord_side_d  = (type_q == 8'h02);
      ord_sym_d   = sym_q;
      ord_price_d = price_q;
      ord_qty_d   = qty_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_HUNT;
      rx_clear_q    <= 1'b0;
      idle_q        <= '0;
      cnt_q         <= '0;
      xor_q         <= '0;
      type_q        <= '0;
      sym_q         <= '0;
      price_q       <= '0;
      qty_q         <= '0;
      ord_valid_q   <= 1'b0;
      ord_side_q    <= 1'b0;
      ord_sym_q     <= '0;
      ord_price_q   <= '0;
      ord_qty_q     <= '0;
      err_cksum_q   <= 1'b0;
      err_type_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_clear_q    <= rx_clear_d;
      idle_q        <= idle_d;
      cnt_q         <= cnt_d;
      xor_q         <= xor_d;
      type_q        <= type_d;
      sym_q         <= sym_d;
      price_q       <= price_d;
      qty_q         <= qty_d;
      ord_valid_q   <= ord_valid_d;
      ord_side_q    <= ord_side_d;
      ord_sym_q     <= ord_sym_d;
      ord_price_q   <= ord_price_d;
      ord_qty_q     <= ord_qty_d;
      err_cksum_q   <= err_cksum_d;
      err_type_q    <= err_type_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign rx_clear    = rx_clear_q;
  assign ord_valid   = ord_valid_q;
  assign ord_side    = ord_side_q;
  assign ord_sym     = ord_sym_q;
  assign ord_price   = ord_price_q;
  assign ord_qty     = ord_qty_q;
  assign err_cksum   = err_cksum_q;
  assign err_type    = err_type_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_order_parser.sv
module tb_uart_order_parser;

  localparam logic [79:0] FR_A   = 80'hA5_01_10_00_00_12_34_00_64_53;
  localparam logic [79:0] FR_BCK = 80'hA5_01_10_00_00_12_34_00_64_52;
  localparam logic [79:0] FR_TYP = 80'hA5_03_10_00_00_12_34_00_64_51;
  localparam logic [79:0] FR_B   = 80'hA5_02_20_00_01_00_00_00_0A_29;
  localparam logic [57:0] ORD_A  = {1'b1, 1'b0, 8'h10, 32'h0000_1234, 16'h0064};
  localparam logic [57:0] ORD_B  = {1'b1, 1'b1, 8'h20, 32'h0001_0000, 16'h000A};

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_clear;
  logic        ord_valid;
  logic        ord_ready;
  logic        ord_side;
  logic [7:0]  ord_sym;
  logic [31:0] ord_price;
  logic [15:0] ord_qty;
  logic        err_cksum, err_type, err_timeout, err_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [57:0] obs;
  logic [3:0]  errs;
  assign obs  = {ord_valid, ord_side, ord_sym, ord_price, ord_qty};
  assign errs = {err_cksum, err_type, err_timeout, err_overrun};

  uart_order_parser #(
    .PRICE_BYTES(4), .TIMEOUT_CYCLES(20), .SOF_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_clear(rx_clear),
    .ord_valid(ord_valid), .ord_ready(ord_ready),
    .ord_side(ord_side), .ord_sym(ord_sym), .ord_price(ord_price), .ord_qty(ord_qty),
    .err_cksum(err_cksum), .err_type(err_type),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Offers one byte and returns #1 after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b, input logic rdy);
    int guard;
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    guard    = 0;
    while (rx_clear === 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) begin
      n_tests++; n_fail++;
      $display("FAIL send_byte_stuck rx_clear=%b after %0d cycles, want 0", rx_clear, guard);
    end
    ord_ready = rdy;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [79:0] f, input logic rdy_body, input logic rdy_ck);
    for (int i = 0; i < 10; i++)
      send_byte(f[79-8*i -: 8], (i == 9) ? rdy_ck : rdy_body);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_ready = 1'b1; rx_data = 8'hA5; ord_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({obs, errs, rx_clear} !== 63'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0", {obs, errs, rx_clear});
    end
    @(negedge clk);
    rx_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_good_frame;
    send_frame(FR_A, 1'b1, 1'b1);
    n_tests++;
    if (obs !== ORD_A || errs !== 4'b0000) begin
      n_fail++;
      $display("FAIL t1_order got %h errs %b want %h errs 0000", obs, errs, ORD_A);
    end
    @(posedge clk); #1;
    n_tests++;
    if (ord_valid !== 1'b0 || errs !== 4'b0000) begin
      n_fail++;
      $display("FAIL t1_drain got valid %b errs %b want 0 0000", ord_valid, errs);
    end
  endtask

  task automatic test_bad_cksum;
    send_frame(FR_BCK, 1'b1, 1'b1);
    n_tests++;
    if (errs !== 4'b1000 || ord_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_cksum_err got errs %b valid %b want 1000 0", errs, ord_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if (errs !== 4'b0000) begin
      n_fail++;
      $display("FAIL t2_single_pulse got errs %b want 0000", errs);
    end
    send_frame(FR_A, 1'b1, 1'b1);
    n_tests++;
    if (obs !== ORD_A || errs !== 4'b0000) begin
      n_fail++;
      $display("FAIL t2_recover got %h errs %b want %h", obs, errs, ORD_A);
    end
    @(posedge clk);
  endtask

  task automatic test_bad_type;
    send_frame(FR_TYP, 1'b1, 1'b1);
    n_tests++;
    if (errs !== 4'b0100 || ord_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_type_err got errs %b valid %b want 0100 0", errs, ord_valid);
    end
  endtask

  task automatic test_overrun;
    send_frame(FR_A, 1'b0, 1'b0);
    n_tests++;
    if (obs !== ORD_A || errs !== 4'b0000) begin
      n_fail++;
      $display("FAIL t4_first got %h errs %b want %h", obs, errs, ORD_A);
    end
    send_frame(FR_B, 1'b0, 1'b0);
    n_tests++;
    if (obs !== ORD_A || errs !== 4'b0001) begin
      n_fail++;
      $display("FAIL t4_overrun got %h errs %b want %h errs 0001", obs, errs, ORD_A);
    end
    send_frame(FR_B, 1'b0, 1'b1);
    n_tests++;
    if (obs !== ORD_B || errs !== 4'b0000) begin
      n_fail++;
      $display("FAIL t4_reload got %h errs %b want %h errs 0000", obs, errs, ORD_B);
    end
    @(posedge clk); #1;
    ord_ready = 1'b0;
    n_tests++;
    if (ord_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_drain got valid %b want 0", ord_valid);
    end
  endtask

  task automatic test_timeout;
    int first_k;
    int pulses;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h10, 1'b1);
    first_k = 0;
    pulses  = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (err_timeout === 1'b1) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
    end
    n_tests++;
    if (first_k != 20 || pulses != 1) begin
      n_fail++;
      $display("FAIL t5_timeout got cycle %0d pulses %0d want cycle 20 pulses 1", first_k, pulses);
    end
    send_byte(8'h00, 1'b1);
    send_frame(FR_A, 1'b1, 1'b1);
    n_tests++;
    if (obs !== ORD_A || errs !== 4'b0000) begin
      n_fail++;
      $display("FAIL t5_resync got %h errs %b want %h", obs, errs, ORD_A);
    end
    // Next byte lands exactly on the limit cycle and must win.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h10, 1'b1);
    repeat (19) @(posedge clk);
    send_byte(8'h00, 1'b1);
    n_tests++;
    if (err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_boundary got err_timeout %b want 0", err_timeout);
    end
    for (int i = 4; i < 10; i++) send_byte(FR_A[79-8*i -: 8], 1'b1);
    n_tests++;
    if (obs !== ORD_A || errs !== 4'b0000) begin
      n_fail++;
      $display("FAIL t5_boundary_order got %h errs %b want %h", obs, errs, ORD_A);
    end
    @(posedge clk);
  endtask

  task automatic test_handshake_reset;
    int bad;
    int highs;
    logic [7:0] partial [5];
    partial = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00};
    @(negedge clk);
    rx_data  = 8'h00;
    rx_ready = 1'b1;
    bad   = 0;
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (rx_clear === 1'b1) highs++;
      if (rx_clear !== ((i % 2) == 0)) bad++;
    end
    rx_ready = 1'b0;
    n_tests++;
    if (bad != 0 || highs != 6) begin
      n_fail++;
      $display("FAIL t6_clear_pattern got %0d highs %0d misplaced want 6 highs 0 misplaced", highs, bad);
    end
    repeat (2) @(posedge clk);
    send_frame(FR_A, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(partial[i], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({obs, errs, rx_clear} !== 63'd0) begin
      n_fail++;
      $display("FAIL t6_reset_mid got %h want 0", {obs, errs, rx_clear});
    end
    @(negedge clk);
    rst = 1'b0;
    send_frame(FR_B, 1'b0, 1'b0);
    n_tests++;
    if (obs !== ORD_B || errs !== 4'b0000) begin
      n_fail++;
      $display("FAIL t6_after_reset got %h errs %b want %h", obs, errs, ORD_B);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_ready  = 1'b0;
    rx_data   = 8'h00;
    ord_ready = 1'b0;
    rst       = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_cksum();
    test_bad_type();
    test_overrun();
    test_timeout();
    test_handshake_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
